// File: rtl/rx_pkg.sv
// Shared definitions for the receive path: state encoding, size defaults
// and the decimation-ratio clamp.
package rx_pkg;

    // Size defaults for the decimation scheduler
    localparam int MAX_DECIMATION_DEF = 16;
    localparam int RATIO_W_DEF        = $clog2(MAX_DECIMATION_DEF + 1);
    localparam int DROP_W_DEF         = 16;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARM   = ST_ARM,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } rx_state_e;

    // Map a requested ratio onto the supported range: 0 behaves as 1,
    // anything above the maximum is pinned to the maximum.
    function automatic int clamp_ratio(input int req, input int max_ratio);
        if (req <= 0) begin
            return 1;
        end else if (req > max_ratio) begin
            return max_ratio;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating up-counter with synchronous clear. An increment in the same
// cycle as a clear wins and leaves the count at one.
module rx_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             crx_clk,
    input  logic             rrx_rst,
    input  logic             iinc,
    input  logic             iclr,
    output logic [WIDTH-1:0] ocnt
);

    // Count events, stick at all-ones, clear on request
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            ocnt <= '0;
        end else if (iinc) begin
            if (iclr) begin
                ocnt <= WIDTH'(1);
            end else if (ocnt != '1) begin
                ocnt <= ocnt + 1'b1;
            end
        end else if (iclr) begin
            ocnt <= '0;
        end
    end

endmodule

// File: rtl/rx_decim_scheduler.sv
// Receive decimation scheduler: thins the input sample strobe by a
// programmable ratio, holds strobes off while the filter is busy, sequences
// enable/disable and counts strobes that had to be dropped.
module rx_decim_scheduler
    import rx_pkg::*;
#(
    parameter int MAX_DECIMATION = MAX_DECIMATION_DEF,
    parameter int RATIO_W        = $clog2(MAX_DECIMATION + 1),
    parameter int DROP_W         = DROP_W_DEF
) (
    input  logic               crx_clk,
    input  logic               rrx_rst,
    input  logic               erx_en,
    input  logic               inew_sample_trigg,
    input  logic [RATIO_W-1:0] icfg_ratio,
    input  logic               icfg_load,
    input  logic               ifilt_busy,
    input  logic               iclr_stat,
    output logic               onew_sample_trigg,
    output logic [RATIO_W-1:0] ophase,
    output logic               orun,
    output logic               ooverrun,
    output logic [DROP_W-1:0]  odrop_cnt
);

    rx_state_e          state_q;
    rx_state_e          state_d;

    logic [RATIO_W-1:0] rratio;
    logic [RATIO_W-1:0] ratio_d;
    logic [RATIO_W-1:0] pend_ratio;
    logic [RATIO_W-1:0] pend_ratio_d;
    logic               pend_valid;
    logic               pend_valid_d;

    logic [RATIO_W-1:0] phase_d;
    logic [RATIO_W-1:0] last_phase;
    logic [RATIO_W-1:0] load_val;

    logic               candidate;
    logic               period_done;
    logic               legal_load;
    logic               drop;
    logic               strobe_d;

    // Last phase of the current period and the sanitised requested ratio
    assign last_phase = rratio - 1'b1;
    assign load_val   = RATIO_W'(clamp_ratio(int'(icfg_ratio), MAX_DECIMATION));

    // Sequencer state register
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, phase advance and candidate detection
    // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        phase_d     = ophase;
        candidate   = 1'b0;
        period_done = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (erx_en) begin
                    state_d = ARM;
                end
            end

            ARM: begin
                phase_d = '0;
                if (!erx_en) begin
                    state_d = IDLE;
                end else if (inew_sample_trigg) begin
                    // First trigger counts as phase 0 of the first period
                    candidate = 1'b1;
                    state_d   = RUN;
                    phase_d   = (rratio == RATIO_W'(1)) ? '0 : RATIO_W'(1);
                end
            end

            RUN: begin
                if (!erx_en) begin
                    // A trigger in the disable cycle is deliberately ignored
                    state_d = DRAIN;
                end else if (inew_sample_trigg) begin
                    candidate = (ophase == '0);
                    if (ophase == last_phase) begin
                        period_done = 1'b1;
                        phase_d     = '0;
                    end else begin
                        phase_d = ophase + 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (!ifilt_busy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A candidate either goes to the filter or is dropped; never both
    assign strobe_d = candidate & ~ifilt_busy;
    assign drop     = candidate & ifilt_busy;

    // Ratio update rules: apply in IDLE or at a period boundary, else park it
    always_comb begin
        ratio_d      = rratio;
        pend_ratio_d = pend_ratio;
        pend_valid_d = pend_valid;
        legal_load   = (state_q == IDLE) || period_done;

        if (legal_load) begin
            if (icfg_load) begin
                ratio_d = load_val;
            end else if (pend_valid) begin
                ratio_d = pend_ratio;
            end
            pend_valid_d = 1'b0;
        end else if (icfg_load) begin
            // A newer request simply overwrites an older parked one
            pend_ratio_d = load_val;
            pend_valid_d = 1'b1;
        end
    end

    // Ratio register and parked load
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            rratio     <= RATIO_W'(1);
            pend_ratio <= RATIO_W'(1);
            pend_valid <= 1'b0;
        end else begin
            rratio     <= ratio_d;
            pend_ratio <= pend_ratio_d;
            pend_valid <= pend_valid_d;
        end
    end

    // Registered outputs: phase, run flag and the one-cycle filter strobe
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            ophase            <= '0;
            orun              <= 1'b0;
            onew_sample_trigg <= 1'b0;
        end else begin
            ophase            <= phase_d;
            orun              <= (state_d == RUN);
            onew_sample_trigg <= strobe_d;
        end
    end

    // Sticky overrun flag; a drop outranks a simultaneous clear
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            ooverrun <= 1'b0;
        end else if (drop) begin
            ooverrun <= 1'b1;
        end else if (iclr_stat) begin
            ooverrun <= 1'b0;
        end
    end

    // Dropped-strobe counter
    rx_sat_counter #(
        .WIDTH (DROP_W)
    ) u_drop_cnt (
        .crx_clk (crx_clk),
        .rrx_rst (rrx_rst),
        .iinc    (drop),
        .iclr    (iclr_stat),
        .ocnt    (odrop_cnt)
    );

endmodule

// File: tb/tb_rx_decim_scheduler.sv
// Directed and randomised bench for rx_decim_scheduler. A second instance
// with a 3-bit drop counter shares all inputs so counter saturation is
// reached in a few cycles.
module tb_rx_decim_scheduler;

    localparam int MAXD = rx_pkg::MAX_DECIMATION_DEF;
    localparam int RW   = rx_pkg::RATIO_W_DEF;
    localparam int DW   = rx_pkg::DROP_W_DEF;
    localparam int SW   = 3;
    localparam int SMAX = (1 << SW) - 1;
    localparam int DMAX = (1 << DW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic          crx_clk = 1'b0;
    logic          rrx_rst;
    logic          erx_en;
    logic          inew_sample_trigg;
    logic [RW-1:0] icfg_ratio;
    logic          icfg_load;
    logic          ifilt_busy;
    logic          iclr_stat;

    logic          onew_sample_trigg;
    logic [RW-1:0] ophase;
    logic          orun;
    logic          ooverrun;
    logic [DW-1:0] odrop_cnt;

    logic          s_strobe;
    logic [RW-1:0] s_phase;
    logic          s_run;
    logic          s_overrun;
    logic [SW-1:0] s_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobes;

    // Reference model state
    int m_mode;
    int m_phase;
    int m_ratio;
    int m_pend;
    int m_drops;
    bit m_overrun;
    bit m_strobe;

    always #5 crx_clk = ~crx_clk;

    rx_decim_scheduler #(
        .MAX_DECIMATION (MAXD),
        .RATIO_W        (RW),
        .DROP_W         (DW)
    ) dut (
        .crx_clk           (crx_clk),
        .rrx_rst           (rrx_rst),
        .erx_en            (erx_en),
        .inew_sample_trigg (inew_sample_trigg),
        .icfg_ratio        (icfg_ratio),
        .icfg_load         (icfg_load),
        .ifilt_busy        (ifilt_busy),
        .iclr_stat         (iclr_stat),
        .onew_sample_trigg (onew_sample_trigg),
        .ophase            (ophase),
        .orun              (orun),
        .ooverrun          (ooverrun),
        .odrop_cnt         (odrop_cnt)
    );

    rx_decim_scheduler #(
        .MAX_DECIMATION (MAXD),
        .RATIO_W        (RW),
        .DROP_W         (SW)
    ) dut_small (
        .crx_clk           (crx_clk),
        .rrx_rst           (rrx_rst),
        .erx_en            (erx_en),
        .inew_sample_trigg (inew_sample_trigg),
        .icfg_ratio        (icfg_ratio),
        .icfg_load         (icfg_load),
        .ifilt_busy        (ifilt_busy),
        .iclr_stat         (iclr_stat),
        .onew_sample_trigg (s_strobe),
        .ophase            (s_phase),
        .orun              (s_run),
        .ooverrun          (s_overrun),
        .odrop_cnt         (s_drop_cnt)
    );

    function automatic int clampr(input int v);
        if (v == 0) return 1;
        if (v > MAXD) return MAXD;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_phase   = 0;
        m_ratio   = 1;
        m_pend    = 0;
        m_drops   = 0;
        m_overrun = 1'b0;
        m_strobe  = 1'b0;
    endtask

    // One clock of the behavioural model, from the inputs present at the edge
    task automatic model_step();
        bit cand;
        bit boundary;
        int req;
        cand     = 1'b0;
        boundary = (m_mode == M_IDLE);
        req      = clampr(int'(icfg_ratio));

        case (m_mode)
            M_IDLE: begin
                m_phase = 0;
                if (erx_en) m_mode = M_ARM;
            end
            M_ARM: begin
                m_phase = 0;
                if (!erx_en) begin
                    m_mode = M_IDLE;
                end else if (inew_sample_trigg) begin
                    cand    = 1'b1;
                    m_phase = 1 % m_ratio;
                    m_mode  = M_RUN;
                end
            end
            M_RUN: begin
                if (!erx_en) begin
                    m_mode = M_DRAIN;
                end else if (inew_sample_trigg) begin
                    cand     = (m_phase == 0);
                    boundary = (m_phase + 1 == m_ratio);
                    m_phase  = (m_phase + 1) % m_ratio;
                end
            end
            default: begin
                if (!ifilt_busy) m_mode = M_IDLE;
            end
        endcase

        if (boundary) begin
            if (icfg_load) m_ratio = req;
            else if (m_pend > 0) m_ratio = m_pend;
            m_pend = 0;
        end else if (icfg_load) begin
            m_pend = req;
        end

        if (iclr_stat) begin
            m_drops   = 0;
            m_overrun = 1'b0;
        end
        if (cand && ifilt_busy) begin
            m_overrun = 1'b1;
            m_drops   = (m_drops < DMAX) ? m_drops + 1 : DMAX;
        end
        m_strobe = cand && !ifilt_busy;
    endtask

    task automatic compare_all();
        int small_exp;
        small_exp = (m_drops > SMAX) ? SMAX : m_drops;
        check("strobe", onew_sample_trigg, m_strobe);
        check("phase", ophase, m_phase);
        check("run", orun, (m_mode == M_RUN));
        check("overrun", ooverrun, m_overrun);
        check("drop_cnt", odrop_cnt, m_drops);
        check("strobe_w3", s_strobe, m_strobe);
        check("overrun_w3", s_overrun, m_overrun);
        check("drop_cnt_w3", s_drop_cnt, small_exp);
    endtask

    // Advance one clock, compare on the falling edge, then retire pulses
    task automatic tick();
        @(posedge crx_clk);
        model_step();
        @(negedge crx_clk);
        compare_all();
        if (onew_sample_trigg) n_strobes++;
        inew_sample_trigg = 1'b0;
        icfg_load         = 1'b0;
        iclr_stat         = 1'b0;
    endtask

    task automatic trig_every(input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            inew_sample_trigg = 1'b1;
            tick();
            for (int g = 1; g < gap; g++) tick();
        end
    endtask

    task automatic load_ratio(input int value);
        icfg_ratio = RW'(value);
        icfg_load  = 1'b1;
        tick();
    endtask

    // Watchdog: the sequence is fixed-length, this only guards against a stuck clock
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rrx_rst           = 1'b1;
        erx_en            = 1'b0;
        inew_sample_trigg = 1'b0;
        icfg_ratio        = '0;
        icfg_load         = 1'b0;
        ifilt_busy        = 1'b0;
        iclr_stat         = 1'b0;
        n_strobes         = 0;
        model_reset();

        // Reset state
        #12;
        compare_all();
        @(negedge crx_clk);
        rrx_rst = 1'b0;
        tick();

        // R = 4, triggers every third cycle: outputs on triggers 1, 5 and 9
        load_ratio(4);
        erx_en = 1'b1;
        tick();
        check("arm_phase", ophase, 0);
        n_strobes = 0;
        trig_every(12, 3);
        check("r4_strobes", n_strobes, 3);

        // Load R = 2 at phase 1; it only lands after phase 3 completes
        trig_every(1, 1);
        check("pre_load_phase", ophase, 1);
        load_ratio(2);
        n_strobes = 0;
        trig_every(3, 1);
        check("r4_wrap_strobes", n_strobes, 0);
        trig_every(8, 1);
        check("r2_strobes", n_strobes, 4);

        // Three dropped candidates at R = 2, then a drop racing a clear
        iclr_stat = 1'b1;
        tick();
        ifilt_busy = 1'b1;
        n_strobes  = 0;
        trig_every(6, 1);
        check("busy_strobes", n_strobes, 0);
        check("drop3_cnt", odrop_cnt, 3);
        check("drop3_flag", ooverrun, 1);
        inew_sample_trigg = 1'b1;
        iclr_stat         = 1'b1;
        tick();
        check("drop_clr_cnt", odrop_cnt, 1);
        check("drop_clr_flag", ooverrun, 1);
        trig_every(1, 1);
        ifilt_busy = 1'b0;

        // Ratio 0 in IDLE behaves as 1: every back-to-back trigger is output
        erx_en = 1'b0;
        tick();
        tick();
        check("idle_run", orun, 0);
        load_ratio(0);
        erx_en = 1'b1;
        tick();
        n_strobes = 0;
        trig_every(8, 1);
        check("r1_strobes", n_strobes, 8);
        ifilt_busy = 1'b1;
        trig_every(10, 1);
        check("r1_drops", odrop_cnt, 11);
        check("sat_w3", s_drop_cnt, SMAX);
        ifilt_busy = 1'b0;

        // Ratio 31 clamps to 16
        erx_en = 1'b0;
        tick();
        tick();
        load_ratio(31);
        erx_en = 1'b1;
        tick();
        n_strobes = 0;
        trig_every(32, 1);
        check("r16_strobes", n_strobes, 2);

        // Disable mid-period with the filter busy for five cycles
        trig_every(3, 1);
        ifilt_busy = 1'b1;
        erx_en     = 1'b0;
        n_strobes  = 0;
        for (int i = 0; i < 5; i++) begin
            inew_sample_trigg = 1'b1;
            tick();
        end
        check("drain_strobes", n_strobes, 0);
        check("drain_run", orun, 0);
        ifilt_busy = 1'b0;
        tick();
        tick();
        erx_en = 1'b1;
        tick();
        check("rearm_phase", ophase, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            erx_en            = ($urandom_range(0, 19) != 0);
            inew_sample_trigg = $urandom_range(0, 1) == 1;
            ifilt_busy        = ($urandom_range(0, 3) == 0);
            icfg_load         = ($urandom_range(0, 15) == 0);
            icfg_ratio        = RW'($urandom);
            iclr_stat         = ($urandom_range(0, 63) == 0);
            tick();
        end

        // Asynchronous reset while running
        erx_en     = 1'b1;
        ifilt_busy = 1'b0;
        load_ratio(3);
        trig_every(4, 1);
        check("pre_reset_run", orun, 1);
        #2;
        rrx_rst = 1'b1;
        #1;
        model_reset();
        check("async_strobe", onew_sample_trigg, 0);
        check("async_phase", ophase, 0);
        check("async_run", orun, 0);
        check("async_overrun", ooverrun, 0);
        check("async_drop", odrop_cnt, 0);
        @(negedge crx_clk);
        compare_all();
        rrx_rst = 1'b0;
        tick();
        tick();
        n_strobes = 0;
        trig_every(4, 1);
        check("post_reset_strobes", n_strobes, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
